// File: rtl/wb_pkg.sv
// Writeback-stage shared types: request payload and grant-source select.
package wb_pkg;

    localparam int unsigned WB_DATA_WIDTH    = 32;
    localparam int unsigned WB_ADDRESS_WIDTH = 5;
    localparam int unsigned WB_NUM_REGS      = 32;
    localparam int unsigned WB_LD_DEPTH      = 4;

    typedef struct packed {
        logic [WB_ADDRESS_WIDTH-1:0] dest;
        logic [WB_DATA_WIDTH-1:0]    data;
    } wb_req_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LD   = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests used to buffer load returns.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = WB_LD_DEPTH
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  logic    pop,
    input  wb_req_t wr_req,
    output wb_req_t head_c,
    output logic    full_c,
    output logic    empty_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full_c  = (count == CNT_W'(DEPTH));
    assign empty_c = (count == '0);
    assign do_push = push && !full_c;
    assign do_pop  = pop && !empty_c;
    assign head_c  = mem[rd_ptr];

    // Pointer and occupancy tracking; push+pop together leaves count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_req;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and buffered load returns onto the
// single register-file write port. A full load FIFO takes priority so the
// load unit is never back-pressured for long; otherwise the ALU wins.
// Optional feature macro: WB_SCOREBOARD_EN adds the pend_vec outstanding-load
// scoreboard (set on ld_issue, cleared when the load is written back).
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = WB_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = WB_ADDRESS_WIDTH,
    parameter int unsigned NUM_REGS      = WB_NUM_REGS,
    parameter int unsigned LD_FIFO_DEPTH = WB_LD_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDRESS_WIDTH-1:0] alu_dest,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [ADDRESS_WIDTH-1:0] ld_dest,
    input  logic [DATA_WIDTH-1:0]    ld_data,
    input  logic                     ld_issue,
    input  logic [ADDRESS_WIDTH-1:0] ld_issue_dest,
    output logic                     rg_wrt_en,
    output logic [ADDRESS_WIDTH-1:0] rg_wrt_dest,
    output logic [DATA_WIDTH-1:0]    rg_wrt_data
`ifdef WB_SCOREBOARD_EN
    ,
    output logic [NUM_REGS-1:0]      pend_vec
`endif
);

    wb_req_t alu_req;
    wb_req_t ld_req;
    wb_req_t ld_head;
    wb_req_t win_req;
    wb_src_e grant;
    logic    fifo_full_c;
    logic    fifo_empty_c;
    logic    ld_push;
    logic    ld_pop;
    logic    wr_en_c;

    // Pack both sources into the common payload format
    always_comb begin
        alu_req      = '0;
        ld_req       = '0;
        alu_req.dest = WB_ADDRESS_WIDTH'(alu_dest);
        alu_req.data = WB_DATA_WIDTH'(alu_data);
        ld_req.dest  = WB_ADDRESS_WIDTH'(ld_dest);
        ld_req.data  = WB_DATA_WIDTH'(ld_data);
    end

    wb_fifo #(
        .DEPTH   (LD_FIFO_DEPTH)
    ) u_ld_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (ld_push),
        .pop     (ld_pop),
        .wr_req  (ld_req),
        .head_c  (ld_head),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c)
    );

    // Readiness depends only on FIFO state, never on this cycle's requests
    assign ld_ready  = !fifo_full_c;
    assign alu_ready = !fifo_full_c;
    assign ld_push   = ld_valid && !fifo_full_c;
    assign ld_pop    = (grant == SRC_LD);

    // Grant select: full FIFO drains first, then ALU, then any buffered load
    always_comb begin
        grant = SRC_NONE;
        if (fifo_full_c) begin
            grant = SRC_LD;
        end else if (alu_valid) begin
            grant = SRC_ALU;
        end else if (!fifo_empty_c) begin
            grant = SRC_LD;
        end
    end

    // Winning payload and write qualification (x0 is consumed but never written)
    always_comb begin
        win_req = '0;
        case (grant)
            SRC_ALU: win_req = alu_req;
            SRC_LD:  win_req = ld_head;
            default: win_req = '0;
        endcase
        wr_en_c = (grant != SRC_NONE) && (win_req.dest != '0);
    end

    // Register-file write port; address/data hold when nothing is written
    always_ff @(posedge clk) begin
        if (rst) begin
            rg_wrt_en   <= 1'b0;
            rg_wrt_dest <= '0;
            rg_wrt_data <= '0;
        end else begin
            rg_wrt_en <= wr_en_c;
            if (wr_en_c) begin
                rg_wrt_dest <= ADDRESS_WIDTH'(win_req.dest);
                rg_wrt_data <= DATA_WIDTH'(win_req.data);
            end
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [NUM_REGS-1:0] pend_next;

    // Scoreboard update: clear on load writeback, then set on issue so set wins
    always_comb begin
        pend_next = pend_vec;
        if ((grant == SRC_LD) && (ld_head.dest != '0)) begin
            pend_next[ld_head.dest] = 1'b0;
        end
        if (ld_issue && (ld_issue_dest != '0)) begin
            pend_next[ld_issue_dest] = 1'b1;
        end
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vec <= '0;
        end else begin
            pend_vec <= pend_next;
        end
    end
`else
    logic unused_sb;
    assign unused_sb = ^{ld_issue, ld_issue_dest, NUM_REGS[0]};
`endif

endmodule
